// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a request/response handshake,
// holds the fetched word for the decoder and steers the next PC on retirement.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;
  localparam logic [XLEN-1:0] JALR_MASK = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] instr_nxt, instr_pc_nxt;
  logic [XLEN-1:0] target;
  logic            valid_nxt, err_nxt, req_nxt;

  // Next-PC candidate; jalr takes priority over pcsrc, and JALR drops bit 0.
  always_comb begin
    target = pc + PC_STEP;
    if (jalr) begin
      target = (rs1_val + imm) & JALR_MASK;
    end else if (pcsrc) begin
      target = pc + imm;
    end
  end

  // Next-state and register-input logic.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    valid_nxt    = instr_valid;
    err_nxt      = misalign_err;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_nxt    = imem_rdata;
          instr_pc_nxt = pc;
          valid_nxt    = 1'b1;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          valid_nxt = 1'b0;
          if (target[1]) begin
            err_nxt   = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt    = target;
            state_nxt = REQ;
          end
        end
      end
      HALT: valid_nxt = 1'b0;
      default: state_nxt = IDLE;
    endcase
    req_nxt = (state_nxt == REQ);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_pc     <= RESET_PC;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      imem_req     <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr        <= instr_nxt;
      instr_pc     <= instr_pc_nxt;
      instr_valid  <= valid_nxt;
      misalign_err <= err_nxt;
      imem_req     <= req_nxt;
    end
  end

  assign imem_addr = pc;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] RST = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        instr_valid, advance, pcsrc, jalr, misalign_err;
  logic [31:0] imm, rs1_val;

  int checks = 0;
  int failures = 0;

  if_fetch_unit #(.RESET_PC(RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .funct3(funct3), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .advance(advance), .pcsrc(pcsrc), .jalr(jalr),
    .imm(imm), .rs1_val(rs1_val), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: a fetch is started, then accepted, then held until retired.
  logic [31:0] m_pc, m_instr, m_instr_pc;
  logic        m_started, m_accepted, m_have, m_err;

  function automatic logic [31:0] model_target();
    logic [31:0] t;
    if (jalr)       t = (rs1_val + imm) & ~32'h1;
    else if (pcsrc) t = m_pc + imm;
    else            t = m_pc + 32'd4;
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST; m_instr <= NOP; m_instr_pc <= RST;
      m_started <= 1'b0; m_accepted <= 1'b0; m_have <= 1'b0; m_err <= 1'b0;
    end else if (!m_err) begin
      if (!m_started) begin
        m_started <= 1'b1;
      end else if (m_have) begin
        if (advance) begin
          m_have <= 1'b0;
          if (model_target() % 4 >= 2) m_err <= 1'b1;
          else m_pc <= model_target();
        end
      end else if (m_accepted) begin
        if (imem_rvalid) begin
          m_have <= 1'b1; m_accepted <= 1'b0;
          m_instr <= imem_rdata; m_instr_pc <= m_pc;
        end
      end else if (imem_ready) begin
        m_accepted <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic m_req;
    m_req = m_started && !m_accepted && !m_have && !m_err;
    chk("m_req", 32'(imem_req), 32'(m_req));
    chk("m_valid", 32'(instr_valid), 32'(m_have));
    chk("m_err", 32'(misalign_err), 32'(m_err));
    chk("m_instr", instr, m_instr);
    chk("m_op", 32'(op), 32'(m_instr[6:0]));
    chk("m_funct3", 32'(funct3), 32'(m_instr[14:12]));
    chk("m_instr_pc", instr_pc, m_instr_pc);
    if (m_req) chk("m_addr", imem_addr, m_pc);
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
  endtask

  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                       input int rdly, input int vdly, output int req_cycles);
    req_cycles = 0;
    imem_ready = 1'b0;
    for (int k = 0; k < rdly; k++) begin
      if (imem_req) req_cycles++;
      chk("bp_addr", imem_addr, exp_addr);
      step();
    end
    if (imem_req) req_cycles++;
    chk("bp_addr", imem_addr, exp_addr);
    imem_ready = 1'b1; step(); imem_ready = 1'b0;
    for (int k = 0; k < vdly; k++) begin
      step();
      chk("valid_delayed", 32'(instr_valid), 32'd0);
    end
    imem_rvalid = 1'b1; imem_rdata = word; step(); imem_rvalid = 1'b0;
    chk("fetch_word", instr, word);
    chk("fetch_pc", instr_pc, exp_addr);
  endtask

  task automatic retire(input logic p, input logic j, input logic [31:0] im, input logic [31:0] r1);
    advance = 1'b1; pcsrc = p; jalr = j; imm = im; rs1_val = r1;
    step();
    advance = 1'b0; pcsrc = 1'b0; jalr = 1'b0; imm = '0; rs1_val = '0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    advance = 1'b0; pcsrc = 1'b0; jalr = 1'b0; imm = '0; rs1_val = '0;
    #12;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0000_0100);

    // First fetch after reset release: valid in the 3rd cycle.
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0100);
    imem_ready = 1'b1; step(); imem_ready = 1'b0;
    chk("wait_req", 32'(imem_req), 32'd0);
    chk("wait_valid", 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; step(); imem_rvalid = 1'b0;
    chk("c3_valid", 32'(instr_valid), 32'd1);
    chk("c3_op", 32'(op), 32'h13);
    chk("c3_funct3", 32'(funct3), 32'd0);
    chk("c3_instr_pc", instr_pc, 32'h0000_0100);

    // Spurious rvalid while holding must not disturb the instruction.
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 1'b0;
    chk("spurious_instr", instr, 32'h0050_0093);
    chk("spurious_valid", 32'(instr_valid), 32'd1);

    retire(1'b0, 1'b0, 32'h40, 32'h0);
    chk("seq_addr", imem_addr, 32'h0000_0104);
    chk("seq_valid", 32'(instr_valid), 32'd0);

    fetch(32'h0000_0104, 32'h00A0_0113, 3, 2, n);
    chk("bp_req_cycles", 32'(n), 32'd4);

    retire(1'b0, 1'b1, 32'h4, 32'hFFFF_FFF8);
    chk("jalr_top_addr", imem_addr, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_006F, 0, 0, n);
    retire(1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    fetch(32'h0000_0000, 32'h0020_9463, 0, 0, n);
    chk("bne_op", 32'(op), 32'h63);
    chk("bne_funct3", 32'(funct3), 32'd1);
    retire(1'b0, 1'b1, 32'h0, 32'h0000_0200);
    chk("goto_200", imem_addr, 32'h0000_0200);
    fetch(32'h0000_0200, 32'hFE00_08E3, 1, 1, n);
    retire(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("branch_back", imem_addr, 32'h0000_01F0);
    fetch(32'h0000_01F0, 32'h0040_8067, 0, 0, n);
    retire(1'b1, 1'b1, 32'h4, 32'h0000_0301);
    chk("jalr_wins", imem_addr, 32'h0000_0304);

    // Misaligned JALR target halts fetch for good.
    fetch(32'h0000_0304, 32'h0000_8067, 0, 0, n);
    retire(1'b0, 1'b1, 32'h0, 32'h0000_0102);
    chk("halt_err", 32'(misalign_err), 32'd1);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    imem_ready = 1'b1; imem_rvalid = 1'b1; advance = 1'b1; imm = 32'h8;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("halt_noreq", 32'(imem_req), 32'd0);
      chk("halt_pc", imem_addr, 32'h0000_0304);
      chk("halt_sticky", 32'(misalign_err), 32'd1);
    end
    imem_ready = 1'b0; imem_rvalid = 1'b0; advance = 1'b0; imm = '0;

    // Reset asserted while waiting for a response, then a late rvalid.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    step();
    imem_ready = 1'b1; step(); imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_err", 32'(misalign_err), 32'd0);
    chk("async_instr", instr, 32'h0000_0013);
    chk("async_instr_pc", instr_pc, 32'h0000_0100);
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step(); step();
    imem_rvalid = 1'b0;
    chk("late_rvalid_valid", 32'(instr_valid), 32'd0);
    chk("late_rvalid_instr", instr, 32'h0000_0013);
    chk("restart_addr", imem_addr, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h0000_0113, 0, 0, n);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      imem_ready  = ($urandom_range(0, 3) != 0);
      imem_rvalid = ($urandom_range(0, 2) != 0);
      imem_rdata  = $urandom;
      advance     = ($urandom_range(0, 2) == 0);
      pcsrc       = ($urandom_range(0, 1) != 0);
      jalr        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) imm = $urandom;
      else imm = {(($urandom_range(0, 1) != 0) ? 20'hFFFFF : 20'h0), 10'($urandom), 2'b00};
      rs1_val = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      if ((m_err && $urandom_range(0, 15) == 0) || $urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
